// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative HI/LO divider: FSM encodings and the
// divide funct codes decoded upstream in the E-stage datapath.
package div_unit_pkg;

    localparam logic [1:0] DIV_IDLE = 2'b00;
    localparam logic [1:0] DIV_ZERO = 2'b01;
    localparam logic [1:0] DIV_ON   = 2'b10;
    localparam logic [1:0] DIV_DONE = 2'b11;

    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; remainder to HI, quotient to LO.
// Holds the pipeline via stall_o until the result is presented in DONE.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   DIV_IDLE | waiting for start_i; latches operands and sign flags
//   DIV_ZERO | divisor was zero; one cycle, then fixed result
//   DIV_ON   | one restoring step per cycle, WIDTH steps total
//   DIV_DONE | hi_o/lo_o valid, ready_o high; hold_i keeps us here
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             annul_i,
    input  logic             hold_i,
    output logic             stall_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNTW = $clog2(WIDTH) + 1;

    logic [1:0]       state;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] absB;
    logic [WIDTH-1:0] aRaw;
    logic             negQ;
    logic             negR;

    logic             aNeg;
    logic             bNeg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] stepRem;
    logic [WIDTH-1:0] stepQuo;
    logic             lastStep;

    assign aNeg = signed_i & a_i[WIDTH-1];
    assign bNeg = signed_i & b_i[WIDTH-1];

    // rem < |b| always holds, so trial's top bit is a clean borrow flag.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, absB};
        stepRem = shifted[WIDTH-1:0];
        stepQuo = {quo[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            stepRem = trial[WIDTH-1:0];
            stepQuo = {quo[WIDTH-2:0], 1'b1};
        end
    end

    assign lastStep = (cnt == CNTW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DIV_IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            absB  <= '0;
            aRaw  <= '0;
            negQ  <= 1'b0;
            negR  <= 1'b0;
            hi_o  <= '0;
            lo_o  <= '0;
        end else if (annul_i) begin
            state <= DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start_i) begin
                        aRaw  <= a_i;
                        quo   <= aNeg ? -a_i : a_i;
                        absB  <= bNeg ? -b_i : b_i;
                        rem   <= '0;
                        cnt   <= '0;
                        negQ  <= aNeg ^ bNeg;
                        negR  <= aNeg;
                        state <= (b_i == '0) ? DIV_ZERO : DIV_ON;
                    end
                end
                DIV_ON: begin
                    rem <= stepRem;
                    quo <= stepQuo;
                    cnt <= cnt + 1'b1;
                    if (lastStep) begin
                        // Most-negative / -1 wraps back to itself here, no trap.
                        hi_o  <= negR ? -stepRem : stepRem;
                        lo_o  <= negQ ? -stepQuo : stepQuo;
                        state <= DIV_DONE;
                    end
                end
                DIV_ZERO: begin
                    hi_o  <= aRaw;
                    lo_o  <= '1;
                    state <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (!hold_i)
                        state <= DIV_IDLE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    assign stall_o = start_i & (state != DIV_DONE) & ~annul_i;
    assign ready_o = (state == DIV_DONE);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed fix-up, divide-by-zero,
// annul, hold and asynchronous reset behaviour.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signedIn;
    logic [31:0] aIn;
    logic [31:0] bIn;
    logic        annul;
    logic        hold;
    logic        stall;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;

    int nVec  = 0;
    int nMiss = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .signed_i(signedIn),
        .a_i     (aIn),
        .b_i     (bIn),
        .annul_i (annul),
        .hold_i  (hold),
        .stall_o (stall),
        .ready_o (ready),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    // Raise start with operands and wait for ready; returns at posedge+2 of the DONE cycle.
    task automatic startAndWait(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                output int cyc, output int stalls, output bit seen);
        @(posedge clk); #1;
        start = 1'b1; signedIn = sgn; aIn = a; bIn = b;
        #1;
        cyc = 0; stalls = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (stall) stalls++;
            if (ready) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #2;
            cyc++;
        end
    endtask

    task automatic runDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expLo, input logic [31:0] expHi,
                          input int expCyc, input string name);
        int  cyc, stalls;
        bit  seen;
        startAndWait(sgn, a, b, cyc, stalls, seen);
        nVec++;
        if (seen !== 1'b1) begin
            nMiss++;
            $display("FAIL %s timeout: ready_o never rose within 100 cycles", name);
        end
        nVec++;
        if (cyc !== expCyc) begin
            nMiss++;
            $display("FAIL %s ready_cycle: got %0d expected %0d", name, cyc, expCyc);
        end
        nVec++;
        if (stalls !== expCyc) begin
            nMiss++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, expCyc);
        end
        nVec++;
        if (lo !== expLo) begin
            nMiss++;
            $display("FAIL %s lo: got %h expected %h", name, lo, expLo);
        end
        nVec++;
        if (hi !== expHi) begin
            nMiss++;
            $display("FAIL %s hi: got %h expected %h", name, hi, expHi);
        end
        start = 1'b0;
        @(posedge clk); #2;
        nVec++;
        if (ready !== 1'b0) begin
            nMiss++;
            $display("FAIL %s back_to_idle: ready_o got %b expected 0", name, ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; signedIn = 1'b0; aIn = '0; bIn = '0;
        annul = 1'b0; hold = 1'b0;
        #2;
        nVec++;
        if ({stall, ready, hi, lo} !== 66'b0) begin
            nMiss++;
            $display("FAIL reset_outputs: got stall=%b ready=%b hi=%h lo=%h expected all 0",
                     stall, ready, hi, lo);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #2;
        nVec++;
        if (ready !== 1'b0) begin
            nMiss++;
            $display("FAIL reset_idle: ready_o got %b expected 0", ready);
        end
    endtask

    task automatic test_divu();
        runDiv(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "divu_100_7");
        runDiv(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 33, "divu_max_1");
        runDiv(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 32'd1, 33, "divu_max_maxm1");
    endtask

    task automatic test_signed();
        runDiv(1'b1, -32'sd7, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, "div_m7_2");
        runDiv(1'b1, 32'd7, -32'sd2, 32'hFFFFFFFD, 32'd1, 33, "div_7_m2");
        runDiv(1'b1, -32'sd8, -32'sd3, 32'd2, 32'hFFFFFFFE, 33, "div_m8_m3");
        runDiv(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33, "div_minint_m1");
    endtask

    task automatic test_div_zero();
        runDiv(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 2, "divu_5_0");
        runDiv(1'b1, -32'sd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 2, "div_m5_0");
    endtask

    task automatic test_annul();
        @(posedge clk); #1;
        start = 1'b1; signedIn = 1'b0; aIn = 32'd100; bIn = 32'd7;
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        #1;
        nVec++;
        if (stall !== 1'b0) begin
            nMiss++;
            $display("FAIL annul_stall: stall_o got %b expected 0", stall);
        end
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        #1;
        nVec++;
        if (ready !== 1'b0) begin
            nMiss++;
            $display("FAIL annul_ready: ready_o got %b expected 0", ready);
        end
        nVec++;
        if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFFB) begin
            nMiss++;
            $display("FAIL annul_retain: got hi=%h lo=%h expected hi=fffffffb lo=ffffffff", hi, lo);
        end
        runDiv(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 33, "divu_9_4_restart");
    endtask

    task automatic test_annul_with_start();
        int readyCnt = 0;
        @(posedge clk); #1;
        start = 1'b1; annul = 1'b1; signedIn = 1'b0; aIn = 32'd100; bIn = 32'd7;
        #1;
        nVec++;
        if (stall !== 1'b0) begin
            nMiss++;
            $display("FAIL annul_start_stall: stall_o got %b expected 0", stall);
        end
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if (ready) readyCnt++;
        end
        nVec++;
        if (readyCnt !== 0) begin
            nMiss++;
            $display("FAIL annul_start_nostart: ready cycles got %0d expected 0", readyCnt);
        end
    endtask

    task automatic test_hold();
        int  cyc, stalls, rc;
        bit  seen;
        startAndWait(1'b0, 32'd1000, 32'd7, cyc, stalls, seen);
        nVec++;
        if (seen !== 1'b1 || cyc !== 33) begin
            nMiss++;
            $display("FAIL hold_setup: seen=%b cycle=%0d expected seen=1 cycle=33", seen, cyc);
        end
        start = 1'b0; hold = 1'b1;
        rc = 0;
        for (int i = 0; i < 20; i++) begin
            if (!ready) break;
            rc++;
            nVec++;
            if (lo !== 32'd142 || hi !== 32'd6) begin
                nMiss++;
                $display("FAIL hold_stable: got hi=%h lo=%h expected hi=6 lo=142", hi, lo);
            end
            if (rc == 6) hold = 1'b0;
            @(posedge clk); #2;
        end
        hold = 1'b0;
        nVec++;
        if (rc !== 6) begin
            nMiss++;
            $display("FAIL hold_ready_cycles: got %0d expected 6", rc);
        end
    endtask

    task automatic test_annul_beats_hold();
        int  cyc, stalls;
        bit  seen;
        startAndWait(1'b0, 32'd50, 32'd6, cyc, stalls, seen);
        start = 1'b0; hold = 1'b1; annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        #1;
        nVec++;
        if (ready !== 1'b0) begin
            nMiss++;
            $display("FAIL annul_over_hold: ready_o got %b expected 0", ready);
        end
        nVec++;
        if (lo !== 32'd8 || hi !== 32'd2) begin
            nMiss++;
            $display("FAIL annul_over_hold_result: got hi=%h lo=%h expected hi=2 lo=8", hi, lo);
        end
        hold = 1'b0;
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        start = 1'b1; signedIn = 1'b0; aIn = 32'd100; bIn = 32'd7;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0; start = 1'b0;
        #1;
        nVec++;
        if ({stall, ready, hi, lo} !== 66'b0) begin
            nMiss++;
            $display("FAIL async_reset: got stall=%b ready=%b hi=%h lo=%h expected all 0",
                     stall, ready, hi, lo);
        end
        @(negedge clk);
        rst = 1'b1;
        runDiv(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 33, "divu_9_4_after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_div_zero();
        test_annul();
        test_annul_with_start();
        test_hold();
        test_annul_beats_hold();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
